rect_corner_tracker: RTL and testbench

//  Upstream feeder for the rectangle-draw stage. Collects per-marker centroid reports
//  (two markers = two opposite rectangle corners), smooths each with an IIR filter,
//  and commits stable corner coordinates once per frame at vertical blank, so the

---
 rtl/rect_corner_tracker.sv | 167 ++++++++++++++++
 tb/tb_rect_corner_tracker.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rect_corner_tracker.sv
// rtl/rect_corner_tracker.sv - IIR-smoothed two-corner tracker with per-frame commit and lock FSM
// Corner coordinates are committed only on the cycle after new_frame_in.
module rect_corner_tracker #(
  parameter int SMOOTH_SHIFT   = 2,
  parameter int TIMEOUT_FRAMES = 4,
  parameter int MIN_SIZE       = 8,
  parameter int H_MAX          = 1279,
  parameter int V_MAX          = 719
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        new_frame_in,
  input  logic        centroid_valid_in,
  input  logic        centroid_sel_in,
  input  logic [10:0] centroid_x_in,
  input  logic [9:0]  centroid_y_in,
  output logic [10:0] x_out_1,
  output logic [9:0]  y_out_1,
  output logic [10:0] x_out_2,
  output logic [9:0]  y_out_2,
  output logic        corners_valid_out,
  output logic        update_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {ACQUIRE = 2'd0, LOCKED = 2'd1, COAST = 2'd2} state_t;

  localparam int MW = $clog2(TIMEOUT_FRAMES + 2);
  localparam logic [MW-1:0] TIMEOUT_M = MW'(TIMEOUT_FRAMES);
  localparam logic [10:0]   H_LIM     = 11'(H_MAX);
  localparam logic [9:0]    V_LIM     = 10'(V_MAX);
  localparam logic [10:0]   MIN_X     = 11'(MIN_SIZE);
  localparam logic [9:0]    MIN_Y     = 10'(MIN_SIZE);

  state_t        state, next_state;
  logic [MW-1:0] miss_cnt, next_miss;
  logic          commit, clear_hist;

  logic [10:0] sx1, sx2;
  logic [9:0]  sy1, sy2;
  logic        seen1, seen2, hist1, hist2;

  logic [10:0] cx, cur_x, new_x, cur_y11, new_y11;
  logic [9:0]  cy;
  logic        cur_hist;
  logic [10:0] dx;
  logic [9:0]  dy;
  logic        frame_ok;

  // Moves shadow toward target by diff >>> SMOOTH_SHIFT; floor shift keeps result between the two.
  function automatic logic [10:0] smooth(input logic [10:0] sh, input logic [10:0] target);
    logic signed [11:0] diff;
    logic [11:0]        sum;
    diff = $signed({1'b0, target}) - $signed({1'b0, sh});
    sum  = {1'b0, sh} + 12'(diff >>> SMOOTH_SHIFT);
    return sum[10:0];
  endfunction

  always_comb begin
    cx       = (centroid_x_in > H_LIM) ? H_LIM : centroid_x_in;
    cy       = (centroid_y_in > V_LIM) ? V_LIM : centroid_y_in;
    cur_x    = centroid_sel_in ? sx2 : sx1;
    cur_y11  = centroid_sel_in ? {1'b0, sy2} : {1'b0, sy1};
    cur_hist = centroid_sel_in ? hist2 : hist1;
    new_x    = cur_hist ? smooth(cur_x, cx) : cx;
    new_y11  = cur_hist ? smooth(cur_y11, {1'b0, cy}) : {1'b0, cy};
    dx       = (sx1 >= sx2) ? (sx1 - sx2) : (sx2 - sx1);
    dy       = (sy1 >= sy2) ? (sy1 - sy2) : (sy2 - sy1);
    frame_ok = seen1 && seen2 && (dx >= MIN_X) && (dy >= MIN_Y);
  end

  always_comb begin
    next_state = state;
    next_miss  = miss_cnt;
    commit     = 1'b0;
    clear_hist = 1'b0;
    if (new_frame_in) begin
      case (state)
        ACQUIRE: if (frame_ok) begin
          next_state = LOCKED;
          commit     = 1'b1;
        end
        LOCKED: if (frame_ok) begin
          commit = 1'b1;
        end else begin
          next_state = COAST;
          next_miss  = MW'(1);
        end
        COAST: if (frame_ok) begin
          next_state = LOCKED;
          next_miss  = '0;
          commit     = 1'b1;
        end else if (miss_cnt + MW'(1) >= TIMEOUT_M) begin
          next_state = ACQUIRE;
          next_miss  = '0;
          clear_hist = 1'b1;
        end else begin
          next_miss = miss_cnt + MW'(1);
        end
        default: next_state = ACQUIRE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= ACQUIRE;
      miss_cnt <= '0;
    end else begin
      state    <= next_state;
      miss_cnt <= next_miss;
    end
  end

  // Frame clear first, so a coincident centroid still marks its corner for the next frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_out_1    <= '0;
      y_out_1    <= '0;
      x_out_2    <= '0;
      y_out_2    <= '0;
      update_out <= 1'b0;
      sx1        <= '0;
      sy1        <= '0;
      sx2        <= '0;
      sy2        <= '0;
      seen1      <= 1'b0;
      seen2      <= 1'b0;
      hist1      <= 1'b0;
      hist2      <= 1'b0;
    end else begin
      update_out <= 1'b0;
      if (new_frame_in) begin
        seen1 <= 1'b0;
        seen2 <= 1'b0;
        if (clear_hist) begin
          hist1 <= 1'b0;
          hist2 <= 1'b0;
        end
        if (commit) begin
          x_out_1    <= sx1;
          y_out_1    <= sy1;
          x_out_2    <= sx2;
          y_out_2    <= sy2;
          update_out <= 1'b1;
        end
      end
      if (centroid_valid_in) begin
        if (centroid_sel_in) begin
          sx2   <= new_x;
          sy2   <= new_y11[9:0];
          seen2 <= 1'b1;
          hist2 <= 1'b1;
        end else begin
          sx1   <= new_x;
          sy1   <= new_y11[9:0];
          seen1 <= 1'b1;
          hist1 <= 1'b1;
        end
      end
    end
  end

  assign corners_valid_out = (state == LOCKED) || (state == COAST);
  assign state_out         = state;

endmodule

// File: tb/tb_rect_corner_tracker.sv
// tb/tb_rect_corner_tracker.sv - directed self-checking bench for rect_corner_tracker
module tb_rect_corner_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_frame = 1'b0;
  logic        cvalid = 1'b0;
  logic        csel = 1'b0;
  logic [10:0] cx = '0;
  logic [9:0]  cy = '0;
  logic [10:0] x1, x2;
  logic [9:0]  y1, y2;
  logic        cvld, upd;
  logic [1:0]  st;

  int checks = 0;
  int failures = 0;

  rect_corner_tracker dut (
    .clk_in(clk), .rst_in(rst), .new_frame_in(new_frame),
    .centroid_valid_in(cvalid), .centroid_sel_in(csel),
    .centroid_x_in(cx), .centroid_y_in(cy),
    .x_out_1(x1), .y_out_1(y1), .x_out_2(x2), .y_out_2(y2),
    .corners_valid_out(cvld), .update_out(upd), .state_out(st)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic centroid(input logic sel, input int x, input int y);
    cvalid = 1'b1; csel = sel; cx = 11'(x); cy = 10'(y);
    @(negedge clk);
    cvalid = 1'b0;
  endtask

  task automatic frame();
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
  endtask

  task automatic check_out(input string tag, input int ex1, input int ey1, input int ex2,
                           input int ey2, input int eupd, input int evld, input int est);
    check({tag, "_x1"}, int'(x1), ex1);
    check({tag, "_y1"}, int'(y1), ey1);
    check({tag, "_x2"}, int'(x2), ex2);
    check({tag, "_y2"}, int'(y2), ey2);
    check({tag, "_upd"}, int'(upd), eupd);
    check({tag, "_vld"}, int'(cvld), evld);
    check({tag, "_st"}, int'(st), est);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_out("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // first lock: direct load
    centroid(1'b0, 100, 50);
    centroid(1'b1, 300, 200);
    frame();
    check_out("lock", 100, 50, 300, 200, 1, 1, 1);
    @(negedge clk);
    check("lock_upd_drop", int'(upd), 0);

    // filtering while locked: 100 -> 120, then 120 -> 95
    centroid(1'b0, 180, 50);
    centroid(1'b1, 300, 200);
    frame();
    check_out("filt_up", 120, 50, 300, 200, 1, 1, 1);
    centroid(1'b0, 20, 50);
    centroid(1'b1, 300, 200);
    frame();
    check_out("filt_dn", 95, 50, 300, 200, 1, 1, 1);

    // only corner 1 for four frames
    centroid(1'b0, 95, 50);
    frame();
    check_out("coast1", 95, 50, 300, 200, 0, 1, 2);
    centroid(1'b0, 95, 50);
    frame();
    check("coast2_st", int'(st), 2);
    centroid(1'b0, 95, 50);
    frame();
    check("coast3_st", int'(st), 2);
    centroid(1'b0, 95, 50);
    frame();
    check_out("timeout", 95, 50, 300, 200, 0, 0, 0);

    // history cleared: next centroids load directly
    centroid(1'b0, 500, 60);
    centroid(1'b1, 300, 200);
    frame();
    check_out("reload", 500, 60, 300, 200, 1, 1, 1);

    // coincident centroid+frame, clamped input filtered into shadow
    cvalid = 1'b1; csel = 1'b0; cx = 11'd2047; cy = 10'd1023; new_frame = 1'b1;
    @(negedge clk);
    cvalid = 1'b0; new_frame = 1'b0;
    check_out("coinc", 500, 60, 300, 200, 0, 1, 2);
    centroid(1'b1, 300, 200);
    frame();
    check_out("coinc_next", 694, 224, 300, 200, 1, 1, 1);

    // asynchronous reset mid-frame
    centroid(1'b0, 10, 10);
    #1 rst = 1'b1;
    #1 check_out("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // too-small rectangle stays in acquire
    centroid(1'b0, 100, 50);
    centroid(1'b1, 104, 200);
    frame();
    check_out("small", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("small_upd", int'(upd), 0);

    // clamp on direct load, then back-to-back frames
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    centroid(1'b0, 2047, 1023);
    centroid(1'b1, 100, 100);
    frame();
    check_out("clamp", 1279, 719, 100, 100, 1, 1, 1);
    frame();
    check_out("b2b", 1279, 719, 100, 100, 0, 1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
